spm_loader: RTL

Boot-time loader that drives the memory-side port of the scratchpad memory (SPM). It accepts a framed byte stream (length header, big-endian data words, checksum) from a byte source such as the UART receiver and writes the words into SPM from address 0 upward. It then reads every word back through the same port and checks the 32-bit sum against the transmitted checksum. It sits in front of the SPM's mem-side port, which is muxed with the CPU MEM stage while the loader is `busy`.

---
 rtl/spm_loader_pkg.sv | 25 ++
 rtl/spm_loader_pack.sv | 34 +++
 rtl/spm_loader.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/spm_loader_pkg.sv
// rtl/spm_loader_pkg.sv - shared encodings and sizes for the SPM boot loader
package spm_loader_pkg;

    // Data word and framing sizes
    localparam int WORD_DATA_W           = 32;
    localparam int LOADER_LEN_W          = 16;
    localparam int LOADER_BYTES_PER_WORD = 4;

    // SPM mem-side port encodings
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;
    localparam logic READ     = 1'b1;
    localparam logic WRITE    = 1'b0;

    // Loader sequencing states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN    = 3'd1,
        ST_DATA   = 3'd2,
        ST_SUM    = 3'd3,
        ST_VERIFY = 3'd4,
        ST_FIN    = 3'd5
    } loader_state_e;

endpackage

// File: rtl/spm_loader_pack.sv
// rtl/spm_loader_pack.sv - byte to big-endian word packer
module spm_loader_pack
    import spm_loader_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear_i,
    input  logic [7:0]             byte_data_i,
    input  logic                   byte_valid_i,
    output logic [WORD_DATA_W-1:0] word_o,
    output logic                   word_valid_o
);

    // The first three bytes of a word wait here; the fourth completes it
    // combinationally so the caller can register the whole word on the
    // same edge that accepts the last byte.
    logic [23:0] shift_q;
    logic [1:0]  cnt_q;

    assign word_o       = {shift_q, byte_data_i};
    assign word_valid_o = byte_valid_i && (cnt_q == 2'(LOADER_BYTES_PER_WORD - 1));

    // Shift accepted bytes in MSB first and count them modulo four
    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (byte_valid_i) begin
            shift_q <= {shift_q[15:0], byte_data_i};
            cnt_q   <= cnt_q + 2'd1;
        end
    end

endmodule

// File: rtl/spm_loader.sv
// rtl/spm_loader.sv - framed byte stream loader and readback verifier for the SPM
module spm_loader
    import spm_loader_pkg::*;
#(
    parameter int SPM_ADDR_W = 12
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic                   rx_ready,
    output logic [SPM_ADDR_W-1:0]  spm_addr,
    output logic                   spm_as_,
    output logic                   spm_rw,
    output logic [WORD_DATA_W-1:0] spm_wr_data,
    input  logic [WORD_DATA_W-1:0] spm_rd_data,
    output logic                   busy,
    output logic                   done,
    output logic                   pass
);

    // One extra bit so a full-capacity load counts to 2^SPM_ADDR_W
    localparam int          CNT_W    = SPM_ADDR_W + 1;
    localparam logic [31:0] CAPACITY = 32'd1 << SPM_ADDR_W;

    loader_state_e           state_q;
    logic                    rx_ready_q;
    logic [SPM_ADDR_W-1:0]   addr_q;
    logic                    as_q;
    logic                    rw_q;
    logic [WORD_DATA_W-1:0]  wr_data_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    pass_q;

    logic [7:0]              len_hi_q;
    logic                    len_cnt_q;
    logic [LOADER_LEN_W-1:0] len_q;
    logic [CNT_W-1:0]        wr_k_q;
    logic [CNT_W-1:0]        rd_k_q;
    logic                    rd_pend_q;
    logic [WORD_DATA_W-1:0]  sum_q;
    logic [WORD_DATA_W-1:0]  csum_q;

    logic                    rx_fire;
    logic                    pack_in;
    logic                    pack_clear;
    logic [WORD_DATA_W-1:0]  pack_word;
    logic                    pack_valid;
    logic [LOADER_LEN_W-1:0] len_next;
    logic                    len_too_big;
    logic                    wr_last;
    logic                    rd_more;
    logic [WORD_DATA_W-1:0]  sum_d;

    assign rx_fire     = rx_valid && rx_ready_q;
    assign pack_in     = rx_fire && ((state_q == ST_DATA) || (state_q == ST_SUM));
    assign pack_clear  = start && (state_q == ST_IDLE);
    assign len_next    = {len_hi_q, rx_data};
    assign len_too_big = 32'(len_next) > CAPACITY;
    assign wr_last     = (32'(wr_k_q) + 32'd1) == 32'(len_q);
    assign rd_more     = 32'(rd_k_q) < 32'(len_q);
    // Read data lands one cycle after its strobe
    assign sum_d       = rd_pend_q ? (sum_q + spm_rd_data) : sum_q;

    spm_loader_pack u_pack (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (pack_clear),
        .byte_data_i  (rx_data),
        .byte_valid_i (pack_in),
        .word_o       (pack_word),
        .word_valid_o (pack_valid)
    );

    // Frame sequencer; every port-facing output is a register set here
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            rx_ready_q <= 1'b0;
            addr_q     <= '0;
            as_q       <= DISABLE_;
            rw_q       <= READ;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            len_hi_q   <= '0;
            len_cnt_q  <= 1'b0;
            len_q      <= '0;
            wr_k_q     <= '0;
            rd_k_q     <= '0;
            rd_pend_q  <= 1'b0;
            sum_q      <= '0;
            csum_q     <= '0;
        end else begin
            // Strobe is a single-cycle pulse unless re-issued below
            as_q      <= DISABLE_;
            rw_q      <= READ;
            rd_pend_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q    <= ST_LEN;
                        busy_q     <= 1'b1;
                        rx_ready_q <= 1'b1;
                        pass_q     <= 1'b0;
                        addr_q     <= '0;
                        sum_q      <= '0;
                        wr_k_q     <= '0;
                        rd_k_q     <= '0;
                        len_cnt_q  <= 1'b0;
                    end
                end

                ST_LEN: begin
                    if (rx_fire) begin
                        if (!len_cnt_q) begin
                            len_hi_q  <= rx_data;
                            len_cnt_q <= 1'b1;
                        end else begin
                            len_q     <= len_next;
                            len_cnt_q <= 1'b0;
                            if (len_next == '0) begin
                                state_q <= ST_SUM;
                            end else if (len_too_big) begin
                                // Oversized image: fail without touching SPM
                                state_q    <= ST_FIN;
                                rx_ready_q <= 1'b0;
                                done_q     <= 1'b1;
                                pass_q     <= 1'b0;
                            end else begin
                                state_q <= ST_DATA;
                            end
                        end
                    end
                end

                ST_DATA: begin
                    if (pack_valid) begin
                        as_q      <= ENABLE_;
                        rw_q      <= WRITE;
                        addr_q    <= wr_k_q[SPM_ADDR_W-1:0];
                        wr_data_q <= pack_word;
                        wr_k_q    <= wr_k_q + CNT_W'(1);
                        if (wr_last) begin
                            state_q <= ST_SUM;
                        end
                    end
                end

                ST_SUM: begin
                    if (pack_valid) begin
                        csum_q     <= pack_word;
                        rx_ready_q <= 1'b0;
                        state_q    <= ST_VERIFY;
                        // First readback goes out on the very next cycle
                        if (rd_more) begin
                            as_q   <= ENABLE_;
                            addr_q <= rd_k_q[SPM_ADDR_W-1:0];
                            rd_k_q <= rd_k_q + CNT_W'(1);
                        end
                    end
                end

                ST_VERIFY: begin
                    rd_pend_q <= (as_q == ENABLE_);
                    sum_q     <= sum_d;
                    if (rd_more) begin
                        as_q   <= ENABLE_;
                        addr_q <= rd_k_q[SPM_ADDR_W-1:0];
                        rd_k_q <= rd_k_q + CNT_W'(1);
                    end else if (as_q == DISABLE_) begin
                        // No read in flight: the word summed now is the last
                        state_q <= ST_FIN;
                        done_q  <= 1'b1;
                        pass_q  <= (sum_d == csum_q);
                    end
                end

                ST_FIN: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end

                default: begin
                    state_q    <= ST_IDLE;
                    rx_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                end
            endcase
        end
    end

    assign rx_ready    = rx_ready_q;
    assign spm_addr    = addr_q;
    assign spm_as_     = as_q;
    assign spm_rw      = rw_q;
    assign spm_wr_data = wr_data_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;

endmodule
